codifica_hamming: RTL and testbench
===================================

# codifica_hamming

Streaming Hamming(15,11) encoder and bit-serial transmitter: the transmit-side counterpart of the Hamming(15,11) single-error corrector. It accepts 11-bit data words over a valid/ready handshake, computes the 15-bit codeword with even parity at positions 1, 2, 4 and 8, and buffers codewords in a small FIFO. It then shifts each codeword out LSB first, one bit per accepted beat, on a serial link with per-bit backpressure.

## Interface
Parameters:
- PROFUNDIDADE, 2, codeword FIFO depth; power of two, ≥ 2.

Ports:
- clk  in  1  single clock; everything samples on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- dado  in  11  data word to encode.
- dado_valid  in  1  `dado` is valid this cycle.
- dado_ready  out  1  FIFO can accept a word; a transfer occurs when `dado_valid && dado_ready`.
- serial  out  1  current codeword bit.
- serial_valid  out  1  `serial` is valid.
- serial_sof  out  1  high with bit 0 (codeword index 0) of each frame.
- serial_ready  in  1  sink accepts the current bit; a beat occurs when `serial_valid && serial_ready`.
- palavras_enviadas  out  8  count of completed frames; wraps 255→0.

## Operation
- Bit mapping, with 0-based codeword index i = position − 1:
  - data bits: dado[0..10] → indices 2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14.
  - parity bits: indices 0, 1, 3, 7.
- Parity equations:
  - p1 (idx 0) = XOR of idx 2, 4, 6, 8, 10, 12, 14.
  - p2 (idx 1) = XOR of idx 2, 5, 6, 9, 10, 13, 14.
  - p4 (idx 3) = XOR of idx 4, 5, 6, 11, 12, 13, 14.
  - p8 (idx 7) = XOR of idx 8–14.
  - Any emitted codeword gives syndrome 0 at the corrector, and the corrector recovers the original `dado`.
- Encoding is combinational on `dado`. The codeword is written into the FIFO on the accepting edge.
- `dado_ready` = FIFO count < PROFUNDIDADE, taken from the registered count. A pop in the same cycle does not raise ready when the FIFO is full.
- Serializer FSM:
  - OCIOSO: `serial_valid` = 0. If the FIFO is not empty, pop into the 15-bit shift register, clear the bit counter, go to TRANSMITE.
  - TRANSMITE: `serial_valid` = 1; `serial` = shift register bit 0; `serial_sof` = (counter == 0).
    - On each beat: shift right, counter +1.
    - On the beat with counter == 14: increment `palavras_enviadas`. Then, if the FIFO is not empty, pop and load the next word with counter = 0 and stay in TRANSMITE; otherwise go to OCIOSO.
  - While `serial_ready` = 0, `serial`, `serial_sof` and `serial_valid` hold stable.
- Simultaneous push into an empty FIFO and idle serializer: the push lands first; the pop happens on the following edge.
- The FIFO never overflows: pushes are gated by `dado_ready`. It never underflows: pops are gated by non-empty.

## Timing
- Reset values: `dado_ready` = 1 (FIFO empty), `serial` = 0, `serial_valid` = 0, `serial_sof` = 0, `palavras_enviadas` = 0, FSM = OCIOSO.
- Latency: a word accepted at edge N (empty FIFO, idle FSM) is popped at edge N+1. Its bit 0 is valid, with `serial_sof` = 1, in the cycle after edge N+1.
- Throughput: with `serial_ready` held at 1 and a non-empty FIFO, frames are back-to-back: 15 cycles per word, no idle gap. Bit 14 of one frame is followed directly by `serial_sof` of the next.
- Reset mid-frame: the frame is aborted and the FIFO emptied. `serial_valid` is 0 in the cycle after the reset edge. No partial frame resumes.
- All outputs are registered except `dado_ready`, which is driven from the registered count.

## Structure
- Shared package `hamming_pkg`, also used by the corrector, holds:
  - localparams: N_DADOS = 11, N_CODIGO = 15, and the parity indices.
  - the data-index table.
  - function `gera_codigo(dado) → [14:0]`.
- Sub-module `fifo_sincrona` (parameterised width/depth; push/pop, cheio/vazio, count) holds the codeword buffer.
- The serializer FSM and frame counter live in the top module.

## Test plan
- Reset, then `dado` = 11'h001 → frame bits LSB first 1,1,1,0,…,0 (codeword 15'h0007); `serial_sof` on the first bit; `palavras_enviadas` = 1.
- `dado` = 11'h7FF, then 11'h400 with `serial_ready` = 1 → codewords 15'h7FFF then 15'h408B, back-to-back, exactly 30 consecutive `serial_valid` cycles.
- Hold `serial_ready` = 0 and push 3 words with PROFUNDIDADE = 2 → 2 words enter the FIFO and 1 sits in the shift register. `dado_ready` drops once the FIFO reaches PROFUNDIDADE (2) and, with `serial_ready` still 0, stays low while `dado_valid` is held with the next word (test-specific: 2 FIFO words buffered plus 1 in the shifter). `serial` stays stable.
- Toggle `serial_ready` randomly over 1000 random words; feed the deserialized frames through the corrector → every output equals the input, with syndrome 0.
- Assert `rst_n` = 0 at bit 7 of a frame → `serial_valid` = 0 the next cycle and the FIFO is empty. The first post-reset word starts with `serial_sof`.
- Send 256 frames → `palavras_enviadas` wraps to 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) definitions: the codeword layout, the parity masks and the encoder
// function. The corrector uses the same package, so both sides agree on the bit mapping.
package hamming_pkg;

    localparam int N_DADOS  = 11;
    localparam int N_CODIGO = 15;

    localparam int IDX_P1 = 0;
    localparam int IDX_P2 = 1;
    localparam int IDX_P4 = 3;
    localparam int IDX_P8 = 7;

    // Codeword index of each data bit, in order dado[0..10].
    localparam int IDX_DADOS [N_DADOS] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

    // Each mask selects the data indices that one parity bit covers.
    localparam logic [N_CODIGO-1:0] MASCARA_P1 = 15'h5554;
    localparam logic [N_CODIGO-1:0] MASCARA_P2 = 15'h6664;
    localparam logic [N_CODIGO-1:0] MASCARA_P4 = 15'h7870;
    localparam logic [N_CODIGO-1:0] MASCARA_P8 = 15'h7F00;

    typedef enum logic {
        OCIOSO,
        TRANSMITE
    } estado_t;

    function automatic logic [N_CODIGO-1:0] gera_codigo(input logic [N_DADOS-1:0] dado);
        logic [N_CODIGO-1:0] c;
        c = '0;
        for (int i = 0; i < N_DADOS; i++) begin
            c[IDX_DADOS[i]] = dado[i];
        end
        c[IDX_P1] = ^(c & MASCARA_P1);
        c[IDX_P2] = ^(c & MASCARA_P2);
        c[IDX_P4] = ^(c & MASCARA_P4);
        c[IDX_P8] = ^(c & MASCARA_P8);
        return c;
    endfunction

endpackage

// File: rtl/fifo_sincrona.sv
// Synchronous FIFO with power-of-two depth. The head word is shown combinationally so a pop
// and a load into the shift register happen on the same edge.
module fifo_sincrona #(
    parameter int LARGURA      = 15,
    parameter int PROFUNDIDADE = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [LARGURA-1:0]            dado_in,
    output logic [LARGURA-1:0]            cabeca,
    output logic                          cheio,
    output logic                          vazio,
    output logic [$clog2(PROFUNDIDADE):0] count
);

    localparam int PW = $clog2(PROFUNDIDADE);
    localparam logic [PW:0] COUNT_CHEIO = (PW + 1)'(PROFUNDIDADE);

    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dado_in;
    end

    assign cabeca = mem[rd_ptr];
    assign cheio  = (count == COUNT_CHEIO);
    assign vazio  = (count == '0);

endmodule

// File: rtl/codifica_hamming.sv
// Hamming(15,11) encoder feeding a codeword FIFO, followed by a bit-serial transmitter that
// sends each codeword LSB first with per-bit backpressure and counts completed frames.
module codifica_hamming
    import hamming_pkg::*;
#(
    parameter int PROFUNDIDADE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_DADOS-1:0]  dado,
    input  logic                dado_valid,
    output logic                dado_ready,
    output logic                serial,
    output logic                serial_valid,
    output logic                serial_sof,
    input  logic                serial_ready,
    output logic [7:0]          palavras_enviadas
);

    localparam int CW = $clog2(PROFUNDIDADE) + 1;
    localparam logic [CW-1:0] PROF_C = CW'(PROFUNDIDADE);

    logic [N_CODIGO-1:0] cabeca;
    logic [N_CODIGO-1:0] shift;
    logic [3:0]          contador;
    logic [CW-1:0]       ocupacao;
    logic                cheio;
    logic                vazio;
    logic                push;
    logic                pop;
    estado_t             estado;

    assign dado_ready = (ocupacao < PROF_C);
    assign push       = dado_valid && !cheio;

    // A pop happens either when idle or on the last beat of a frame, so frames run back-to-back.
    assign pop = !vazio && ((estado == OCIOSO) ||
                            (estado == TRANSMITE && serial_ready && contador == 4'd14));

    fifo_sincrona #(
        .LARGURA      (N_CODIGO),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .dado_in (gera_codigo(dado)),
        .cabeca  (cabeca),
        .cheio   (cheio),
        .vazio   (vazio),
        .count   (ocupacao)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado            <= OCIOSO;
            shift             <= '0;
            contador          <= '0;
            serial            <= 1'b0;
            serial_valid      <= 1'b0;
            serial_sof        <= 1'b0;
            palavras_enviadas <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (!vazio) begin
                        shift        <= cabeca;
                        contador     <= '0;
                        serial       <= cabeca[0];
                        serial_valid <= 1'b1;
                        serial_sof   <= 1'b1;
                        estado       <= TRANSMITE;
                    end
                end
                TRANSMITE: begin
                    if (serial_ready) begin
                        if (contador == 4'd14) begin
                            palavras_enviadas <= palavras_enviadas + 8'd1;
                            if (!vazio) begin
                                shift      <= cabeca;
                                contador   <= '0;
                                serial     <= cabeca[0];
                                serial_sof <= 1'b1;
                            end else begin
                                serial       <= 1'b0;
                                serial_valid <= 1'b0;
                                serial_sof   <= 1'b0;
                                estado       <= OCIOSO;
                            end
                        end else begin
                            shift      <= shift >> 1;
                            serial     <= shift[1];
                            serial_sof <= 1'b0;
                            contador   <= contador + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codifica_hamming.sv
// Self-checking bench for codifica_hamming: directed and random words are compared against an
// arithmetic Hamming model, with a serial monitor reassembling frames from accepted beats.
module tb_codifica_hamming;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] dado = '0;
    logic        dado_valid = 1'b0;
    logic        dado_ready;
    logic        serial;
    logic        serial_valid;
    logic        serial_sof;
    logic        serial_ready;
    logic [7:0]  palavras_enviadas;

    int passed = 0;
    int total  = 0;

    logic [14:0] rx_q[$];
    logic [14:0] exp_q[$];
    logic [10:0] sent_q[$];

    int          bit_idx = 0;
    int          run_len = 0;
    int          last_run = 0;
    int          valid_cycles = 0;
    int          sof_err = 0;
    logic [14:0] cur = '0;

    bit   rand_mode = 1'b0;
    logic ready_fixed = 1'b1;

    codifica_hamming #(.PROFUNDIDADE(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dado              (dado),
        .dado_valid        (dado_valid),
        .dado_ready        (dado_ready),
        .serial            (serial),
        .serial_valid      (serial_valid),
        .serial_sof        (serial_sof),
        .serial_ready      (serial_ready),
        .palavras_enviadas (palavras_enviadas)
    );

    always #5 clk = ~clk;

    // Reference encoder: data fills the non-power-of-two positions 1..15 in order, and each
    // parity position p is the even parity of every other position whose number has bit p set.
    function automatic logic [14:0] modelo_codifica(input logic [10:0] d);
        logic [14:0] cw;
        int j;
        cw = '0;
        j = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[j];
                j++;
            end
        end
        for (int p = 1; p <= 8; p = p * 2) begin
            logic par;
            par = 1'b0;
            for (int pos = 1; pos <= 15; pos++) begin
                if ((pos & p) != 0 && pos != p) par = par ^ cw[pos-1];
            end
            cw[p-1] = par;
        end
        return cw;
    endfunction

    function automatic int sindrome(input logic [14:0] cw);
        int s;
        s = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if (cw[pos-1]) s = s ^ pos;
        end
        return s;
    endfunction

    function automatic logic [10:0] extrai_dado(input logic [14:0] cw);
        logic [10:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = cw[pos-1];
                j++;
            end
        end
        return d;
    endfunction

    // Sink-side ready: either a fixed level or a coin flip each cycle.
    initial begin
        serial_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            serial_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    // Serial monitor: reassembles frames from beats and tracks valid run lengths.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bit_idx = 0;
                run_len = 0;
            end else begin
                if (serial_valid) begin
                    run_len++;
                    valid_cycles++;
                end else begin
                    if (run_len > 0) last_run = run_len;
                    run_len = 0;
                end
                if (serial_valid && serial_ready) begin
                    if (serial_sof != (bit_idx == 0)) sof_err++;
                    cur[bit_idx] = serial;
                    if (bit_idx == 14) begin
                        rx_q.push_back(cur);
                        bit_idx = 0;
                    end else begin
                        bit_idx++;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic applyStimulus(input logic [10:0] d);
        bit ok;
        ok = 1'b0;
        dado = d;
        dado_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ok = dado_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        dado_valid = 1'b0;
        if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
        exp_q.push_back(modelo_codifica(d));
    endtask

    task automatic waitFrames(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) break;
            @(negedge clk);
        end
        checkOutput("frame_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clearQueues();
        rx_q.delete();
        exp_q.delete();
        sent_q.delete();
        sof_err = 0;
    endtask

    initial begin
        logic [10:0] w;
        int bad_enc;
        int bad_syn;
        int bad_dat;

        $display("[TB] start");

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_dado_ready", 32'(dado_ready), 32'd1);
        checkOutput("rst_serial_valid", 32'(serial_valid), 32'd0);
        checkOutput("rst_serial_sof", 32'(serial_sof), 32'd0);
        checkOutput("rst_serial", 32'(serial), 32'd0);
        checkOutput("rst_palavras", 32'(palavras_enviadas), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word 11'h001: latency and frame contents.
        ready_fixed = 1'b1;
        clearQueues();
        applyStimulus(11'h001);
        @(negedge clk);
        checkOutput("lat_idle", 32'(serial_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_first_bit", 32'({serial_valid, serial_sof, serial}), 32'b111);
        waitFrames(1, 100);
        checkOutput("frame_001", 32'(rx_q[0]), 32'h0007);
        @(negedge clk);
        checkOutput("palavras_1", 32'(palavras_enviadas), 32'd1);
        checkOutput("sof_001", 32'(sof_err), 32'd0);

        // Back-to-back frames 11'h7FF then 11'h400.
        repeat (5) @(posedge clk);
        #1;
        clearQueues();
        last_run = 0;
        applyStimulus(11'h7FF);
        applyStimulus(11'h400);
        waitFrames(2, 200);
        repeat (3) @(negedge clk);
        checkOutput("frame_7ff", 32'(rx_q[0]), 32'h7FFF);
        checkOutput("frame_400", 32'(rx_q[1]), 32'h408B);
        checkOutput("b2b_model0", 32'(rx_q[0]), 32'(exp_q[0]));
        checkOutput("b2b_model1", 32'(rx_q[1]), 32'(exp_q[1]));
        checkOutput("b2b_run", 32'(last_run), 32'd30);

        // Backpressure: three words fill shifter plus FIFO, the fourth is held off.
        repeat (5) @(posedge clk);
        #1;
        clearQueues();
        ready_fixed = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) applyStimulus(11'($urandom));
        w = 11'($urandom);
        dado = w;
        dado_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("hold_ready", 32'(dado_ready), 32'd0);
            checkOutput("hold_serial", 32'({serial_valid, serial_sof, serial}),
                        32'({2'b11, exp_q[0][0]}));
        end
        ready_fixed = 1'b1;
        applyStimulus(w);
        waitFrames(4, 400);
        bad_enc = 0;
        for (int k = 0; k < 4; k++) if (rx_q[k] !== exp_q[k]) bad_enc++;
        checkOutput("hold_frames", 32'(bad_enc), 32'd0);

        // Random words with random sink backpressure, decoded by the corrector model.
        repeat (5) @(posedge clk);
        #1;
        clearQueues();
        rand_mode = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            w = 11'($urandom);
            sent_q.push_back(w);
            applyStimulus(w);
        end
        waitFrames(1000, 60000);
        rand_mode = 1'b0;
        bad_enc = 0;
        bad_syn = 0;
        bad_dat = 0;
        for (int k = 0; k < rx_q.size() && k < 1000; k++) begin
            if (rx_q[k] !== exp_q[k]) bad_enc++;
            if (sindrome(rx_q[k]) != 0) bad_syn++;
            if (extrai_dado(rx_q[k]) !== sent_q[k]) bad_dat++;
        end
        checkOutput("rand_encode", 32'(bad_enc), 32'd0);
        checkOutput("rand_syndrome", 32'(bad_syn), 32'd0);
        checkOutput("rand_data", 32'(bad_dat), 32'd0);
        checkOutput("rand_sof", 32'(sof_err), 32'd0);

        // Reset at bit 7 of a frame, with a second word waiting in the FIFO.
        repeat (5) @(posedge clk);
        #1;
        clearQueues();
        ready_fixed = 1'b1;
        applyStimulus(11'h2A5);
        applyStimulus(11'h15A);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (serial_valid && serial_sof) break;
        end
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid_cycles = 0;
        @(negedge clk);
        checkOutput("midrst_valid", 32'(serial_valid), 32'd0);
        checkOutput("midrst_ready", 32'(dado_ready), 32'd1);
        checkOutput("midrst_palavras", 32'(palavras_enviadas), 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("midrst_no_resume", 32'(valid_cycles), 32'd0);
        @(posedge clk);
        #1;
        clearQueues();
        applyStimulus(11'h3C3);
        waitFrames(1, 100);
        checkOutput("midrst_frame", 32'(rx_q[0]), 32'(exp_q[0]));
        checkOutput("midrst_sof", 32'(sof_err), 32'd0);

        // Frame counter wrap after 256 frames.
        resetDut();
        clearQueues();
        for (int k = 0; k < 255; k++) applyStimulus(11'($urandom));
        waitFrames(255, 6000);
        @(negedge clk);
        checkOutput("palavras_255", 32'(palavras_enviadas), 32'd255);
        applyStimulus(11'($urandom));
        waitFrames(256, 200);
        @(negedge clk);
        checkOutput("palavras_wrap", 32'(palavras_enviadas), 32'd0);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
